// File: rtl/uart_cmd_master.sv
// uart_cmd_master
// Host-side initiator for the UART command protocol. A parallel command is
// turned into a byte frame on a valid/ready TX port; response bytes from the
// RX strobe stream are collected into one 16-bit result word.
//
// Handshakes: CMD is accepted on CMD_VALID & CMD_READY (READY only in IDLE).
// A TX byte is transferred on TX_VALID & TX_READY; TX_VALID/TX_DATA hold
// until then. RX_VALID is a one-cycle strobe with no back-pressure.
//
// Optional feature macro: RSP_TIMEOUT_EN
//   defined   -> 13-bit response timeout counter, RSP_TIMEOUT reports expiry
//   undefined -> WAIT_RSP waits forever, RSP_TIMEOUT tied low
//
// STATE_DBG exposes the FSM state encoding (0 IDLE, 1 SEND, 2 WAIT_RSP, 3 DONE).

module uart_cmd_master #(
    parameter int OP_WIDTH       = 8,
    parameter int ADDR           = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [1:0]          CMD_TYPE,
    input  logic [ADDR-1:0]     CMD_ADDR,
    input  logic [OP_WIDTH-1:0] CMD_DATA,
    input  logic [OP_WIDTH-1:0] CMD_A,
    input  logic [OP_WIDTH-1:0] CMD_B,
    input  logic [3:0]          CMD_FUN,
    output logic [7:0]          TX_DATA,
    output logic                TX_VALID,
    input  logic                TX_READY,
    input  logic [7:0]          RX_DATA,
    input  logic                RX_VALID,
    output logic                RSP_VALID,
    output logic [15:0]         RSP_DATA,
    output logic                RSP_TIMEOUT,
    output logic [1:0]          STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] T_RF_WR   = 2'd0;
    localparam logic [1:0] T_RF_RD   = 2'd1;
    localparam logic [1:0] T_ALU_OP  = 2'd2;
    localparam logic [1:0] T_ALU_NOP = 2'd3;

    state_t                state;
    logic [1:0]            c_type;
    logic [ADDR-1:0]       c_addr;
    logic [OP_WIDTH-1:0]   c_data;
    logic [OP_WIDTH-1:0]   c_a;
    logic [OP_WIDTH-1:0]   c_b;
    logic [3:0]            c_fun;
    logic [1:0]            idx;
    logic                  rx_idx;
    logic [7:0]            next_byte;
    logic [1:0]            next_idx;
    logic                  rx_last;

`ifdef RSP_TIMEOUT_EN
    localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYCLES - 1);
    logic [12:0]           to_cnt;
`endif

    // Frame header byte selected by command type.
    function automatic logic [7:0] header_byte(input logic [1:0] t);
        case (t)
            T_RF_WR:  header_byte = 8'hAA;
            T_RF_RD:  header_byte = 8'hBB;
            T_ALU_OP: header_byte = 8'hCC;
            default:  header_byte = 8'hDD;
        endcase
    endfunction

    // Index of the final byte of the frame.
    function automatic logic [1:0] last_idx(input logic [1:0] t);
        case (t)
            T_RF_WR:  last_idx = 2'd2;
            T_RF_RD:  last_idx = 2'd1;
            T_ALU_OP: last_idx = 2'd3;
            default:  last_idx = 2'd1;
        endcase
    endfunction

    // Number of response bytes expected for the command type.
    function automatic logic [1:0] rsp_count(input logic [1:0] t);
        case (t)
            T_RF_WR: rsp_count = 2'd0;
            T_RF_RD: rsp_count = 2'd1;
            default: rsp_count = 2'd2;
        endcase
    endfunction

    assign STATE_DBG = state;
    assign next_idx  = idx + 2'd1;
    // Second response byte is the last one only for two-byte responses.
    assign rx_last   = (rsp_count(c_type) == 2'd1) || rx_idx;

    // Payload byte that follows the one currently on TX_DATA.
    always_comb begin
        next_byte = 8'h00;
        case (c_type)
            T_RF_WR: begin
                if (next_idx == 2'd1) next_byte = {{(8-ADDR){1'b0}}, c_addr};
                else                  next_byte = c_data;
            end
            T_RF_RD: begin
                next_byte = {{(8-ADDR){1'b0}}, c_addr};
            end
            T_ALU_OP: begin
                case (next_idx)
                    2'd1:    next_byte = c_a;
                    2'd2:    next_byte = c_b;
                    default: next_byte = {4'h0, c_fun};
                endcase
            end
            default: begin
                next_byte = {4'h0, c_fun};
            end
        endcase
    end

    // Command FSM: accept, serialise the frame, gather response, pulse result.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            CMD_READY <= 1'b1;
            TX_VALID  <= 1'b0;
            TX_DATA   <= 8'h00;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= 16'h0000;
            c_type    <= 2'd0;
            c_addr    <= '0;
            c_data    <= '0;
            c_a       <= '0;
            c_b       <= '0;
            c_fun     <= 4'h0;
            idx       <= 2'd0;
            rx_idx    <= 1'b0;
`ifdef RSP_TIMEOUT_EN
            RSP_TIMEOUT <= 1'b0;
            to_cnt      <= 13'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        c_type    <= CMD_TYPE;
                        c_addr    <= CMD_ADDR;
                        c_data    <= CMD_DATA;
                        c_a       <= CMD_A;
                        c_b       <= CMD_B;
                        c_fun     <= CMD_FUN;
                        idx       <= 2'd0;
                        rx_idx    <= 1'b0;
                        TX_VALID  <= 1'b1;
                        TX_DATA   <= header_byte(CMD_TYPE);
                        CMD_READY <= 1'b0;
                        RSP_DATA  <= 16'h0000;
                        state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (TX_READY) begin
                        if (idx == last_idx(c_type)) begin
                            TX_VALID <= 1'b0;
                            if (rsp_count(c_type) == 2'd0) begin
                                RSP_VALID <= 1'b1;
                                state     <= S_DONE;
                            end else begin
`ifdef RSP_TIMEOUT_EN
                                to_cnt <= 13'd0;
`endif
                                state <= S_WAIT;
                            end
                        end else begin
                            idx     <= next_idx;
                            TX_DATA <= next_byte;
                        end
                    end
                end

                S_WAIT: begin
                    if (RX_VALID) begin
                        if (!rx_idx) RSP_DATA[7:0]  <= RX_DATA;
                        else         RSP_DATA[15:8] <= RX_DATA;
                        rx_idx <= 1'b1;
                        if (rx_last) begin
                            RSP_VALID <= 1'b1;
                            state     <= S_DONE;
                        end
`ifdef RSP_TIMEOUT_EN
                        // A byte landing in the expiry cycle is kept; expiry
                        // still fires when the response remains incomplete.
                        else if (to_cnt == TO_LAST) begin
                            RSP_VALID   <= 1'b1;
                            RSP_TIMEOUT <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            to_cnt <= 13'd0;
                        end
`endif
                    end
`ifdef RSP_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        RSP_VALID   <= 1'b1;
                        RSP_TIMEOUT <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        to_cnt <= to_cnt + 13'd1;
                    end
`endif
                end

                default: begin
                    RSP_VALID <= 1'b0;
`ifdef RSP_TIMEOUT_EN
                    RSP_TIMEOUT <= 1'b0;
`endif
                    CMD_READY <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifndef RSP_TIMEOUT_EN
    assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: table of directed command vectors plus
// hand-written sequences for stray RX bytes, reset mid-frame and timeout.

module tb_uart_cmd_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE = 2'd0;
    logic [3:0]  CMD_ADDR = 4'h0;
    logic [7:0]  CMD_DATA = 8'h00;
    logic [7:0]  CMD_A = 8'h00;
    logic [7:0]  CMD_B = 8'h00;
    logic [3:0]  CMD_FUN = 4'h0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        RSP_VALID;
    logic [15:0] RSP_DATA;
    logic        RSP_TIMEOUT;
    logic [1:0]  STATE_DBG;

    int n_checks = 0;
    int n_fail   = 0;

    uart_cmd_master #(
        .OP_WIDTH(8),
        .ADDR(4),
`ifdef RSP_TIMEOUT_EN
        .TIMEOUT_CYCLES(16)
`else
        .TIMEOUT_CYCLES(4096)
`endif
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_A(CMD_A), .CMD_B(CMD_B),
        .CMD_FUN(CMD_FUN),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_TIMEOUT(RSP_TIMEOUT),
        .STATE_DBG(STATE_DBG)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]       typ;
        logic [3:0]       addr;
        logic [7:0]       data;
        logic [7:0]       a;
        logic [7:0]       b;
        logic [3:0]       fun;
        logic             toggle;
        logic [2:0]       n_tx;
        logic [3:0][7:0]  tx;
        logic [1:0]       n_rx;
        logic [1:0][7:0]  rx;
        logic [15:0]      rsp;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] typ, input logic [3:0] addr,
                                input logic [7:0] data, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] fun,
                                input logic toggle, input logic [2:0] n_tx,
                                input logic [31:0] tx, input logic [1:0] n_rx,
                                input logic [15:0] rx, input logic [15:0] rsp);
        vec_t v;
        v.typ = typ; v.addr = addr; v.data = data; v.a = a; v.b = b;
        v.fun = fun; v.toggle = toggle; v.n_tx = n_tx; v.tx = tx;
        v.n_rx = n_rx; v.rx = rx; v.rsp = rsp;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // driver: present command, handshake, walk the TX frame
    task automatic send_cmd(input vec_t v);
        CMD_TYPE = v.typ; CMD_ADDR = v.addr; CMD_DATA = v.data;
        CMD_A = v.a; CMD_B = v.b; CMD_FUN = v.fun;
        CMD_VALID = 1'b1;
        check("cmd_ready_idle", CMD_READY, 1);
        tick();
        CMD_VALID = 1'b0;
        check("cmd_ready_busy", CMD_READY, 0);
        for (int i = 0; i < int'(v.n_tx); i++) begin
            if (v.toggle) begin
                TX_READY = 1'b0;
                check("tx_valid_hold", TX_VALID, 1);
                check("tx_data_hold", TX_DATA, {8'h00, v.tx[i]});
                tick();
            end
            TX_READY = 1'b1;
            check("tx_valid", TX_VALID, 1);
            check("tx_data", TX_DATA, {8'h00, v.tx[i]});
            tick();
        end
        TX_READY = 1'b0;
        check("tx_valid_end", TX_VALID, 0);
    endtask

    // driver: feed RX bytes and check the result strobe and its timing
    task automatic finish_rsp(input vec_t v);
        if (v.n_rx != 2'd0) begin
            check("no_early_rsp", RSP_VALID, 0);
            for (int j = 0; j < int'(v.n_rx); j++) begin
                RX_VALID = 1'b1;
                RX_DATA  = v.rx[j];
                tick();
                RX_VALID = 1'b0;
                if (j < int'(v.n_rx) - 1) begin
                    check("rsp_mid", RSP_VALID, 0);
                    tick();
                end
            end
        end
        check("rsp_valid", RSP_VALID, 1);
        check("rsp_data", RSP_DATA, v.rsp);
        check("rsp_timeout", RSP_TIMEOUT, 0);
        tick();
        check("rsp_pulse_end", RSP_VALID, 0);
        check("ready_after", CMD_READY, 1);
        check("rsp_data_hold", RSP_DATA, v.rsp);
    endtask

    task automatic run_vec(input vec_t v);
        send_cmd(v);
        finish_rsp(v);
    endtask

    vec_t vecs[7];

    initial begin
        int seen;
        int lat;
        vec_t v;

        vecs[0] = mk(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 3'd3,
                     {8'h00, 8'h3C, 8'h05, 8'hAA}, 2'd0, 16'h0000, 16'h0000);
        vecs[1] = mk(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 3'd2,
                     {8'h00, 8'h00, 8'h02, 8'hBB}, 2'd1, {8'h00, 8'h5A}, 16'h005A);
        vecs[2] = mk(2'd2, 4'h0, 8'h00, 8'h0F, 8'h03, 4'h2, 1'b0, 3'd4,
                     {8'h02, 8'h03, 8'h0F, 8'hCC}, 2'd2, {8'h00, 8'h2D}, 16'h002D);
        vecs[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 3'd2,
                     {8'h00, 8'h00, 8'h00, 8'hDD}, 2'd2, {8'h34, 8'h12}, 16'h3412);
        vecs[4] = mk(2'd0, 4'hF, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b1, 3'd3,
                     {8'h00, 8'hFF, 8'h0F, 8'hAA}, 2'd0, 16'h0000, 16'h0000);
        vecs[5] = mk(2'd1, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 3'd2,
                     {8'h00, 8'h00, 8'h00, 8'hBB}, 2'd1, {8'h00, 8'h80}, 16'h0080);
        vecs[6] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF, 1'b0, 3'd2,
                     {8'h00, 8'h00, 8'h0F, 8'hDD}, 2'd2, {8'hFF, 8'hFF}, 16'hFFFF);

        // reset state
        repeat (3) tick();
        check("rst_cmd_ready", CMD_READY, 1);
        check("rst_tx_valid", TX_VALID, 0);
        check("rst_tx_data", TX_DATA, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_data", RSP_DATA, 0);
        check("rst_rsp_timeout", RSP_TIMEOUT, 0);
        RST = 1'b0;
        tick();
        check("idle_state", STATE_DBG, 0);

        // table-driven commands
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            tick();
        end

        // stray RX byte in IDLE is ignored
        RX_VALID = 1'b1; RX_DATA = 8'h77;
        tick();
        RX_VALID = 1'b0;
        check("stray_rsp_valid", RSP_VALID, 0);
        check("stray_rsp_data", RSP_DATA, 16'hFFFF);
        check("stray_state", STATE_DBG, 0);
        run_vec(mk(2'd1, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 3'd2,
                   {8'h00, 8'h00, 8'h07, 8'hBB}, 2'd1, {8'h00, 8'h11}, 16'h0011));
        // excess RX byte after DONE is ignored
        RX_VALID = 1'b1; RX_DATA = 8'h99;
        tick();
        RX_VALID = 1'b0;
        tick();
        check("excess_rsp_valid", RSP_VALID, 0);
        check("excess_rsp_data", RSP_DATA, 16'h0011);

        // reset while ALU_OP byte 2 is on the wire
        v = mk(2'd2, 4'h0, 8'h00, 8'h11, 8'h22, 4'h3, 1'b0, 3'd4,
               {8'h03, 8'h22, 8'h11, 8'hCC}, 2'd2, 16'h0000, 16'h0000);
        CMD_TYPE = v.typ; CMD_A = v.a; CMD_B = v.b; CMD_FUN = v.fun;
        CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        TX_READY = 1'b1;
        check("rm_byte0", TX_DATA, 16'h00CC);
        tick();
        check("rm_byte1", TX_DATA, 16'h0011);
        tick();
        check("rm_byte2", TX_DATA, 16'h0022);
        check("rm_valid_before", TX_VALID, 1);
        RST = 1'b1;
        #1;
        check("rm_tx_valid_async", TX_VALID, 0);
        check("rm_cmd_ready", CMD_READY, 1);
        check("rm_rsp_valid", RSP_VALID, 0);
        check("rm_rsp_data", RSP_DATA, 0);
        TX_READY = 1'b0;
        tick();
        RST = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (RSP_VALID) seen++;
        end
        check("rm_no_rsp", 16'(seen), 0);
        check("rm_ready_after", CMD_READY, 1);
        run_vec(mk(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 3'd2,
                   {8'h00, 8'h00, 8'h09, 8'hBB}, 2'd1, {8'h00, 8'hA5}, 16'h00A5));
        tick();

        // single response byte for a two-byte command
        v = mk(2'd2, 4'h0, 8'h00, 8'h01, 8'h02, 4'h1, 1'b0, 3'd4,
               {8'h01, 8'h02, 8'h01, 8'hCC}, 2'd2, 16'h0000, 16'h0000);
        send_cmd(v);
        RX_VALID = 1'b1; RX_DATA = 8'h9A;
        tick();
        RX_VALID = 1'b0;
        lat = 0;
        for (int k = 1; k <= 1000; k++) begin
            if (RSP_VALID) begin
                lat = k - 1;
                break;
            end
            tick();
        end
`ifdef RSP_TIMEOUT_EN
        check("to_latency", 16'(lat), 16);
        check("to_flag", RSP_TIMEOUT, 1);
        check("to_data", RSP_DATA, 16'h009A);
        tick();
        check("to_pulse_end", RSP_VALID, 0);
        check("to_flag_end", RSP_TIMEOUT, 0);
`else
        check("no_timeout_rsp", 16'(lat), 0);
        check("no_timeout_valid", RSP_VALID, 0);
        check("wait_state", STATE_DBG, 2);
        RX_VALID = 1'b1; RX_DATA = 8'h55;
        tick();
        RX_VALID = 1'b0;
        check("late_rsp_valid", RSP_VALID, 1);
        check("late_rsp_data", RSP_DATA, 16'h559A);
        check("late_rsp_timeout", RSP_TIMEOUT, 0);
        tick();
`endif
        check("final_ready", CMD_READY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
